// File: rtl/hs_pkg.sv
// Shared types and defaults for the 4-phase handshake responder.
package hs_pkg;

  localparam int HS_CNT_W       = 16;
  localparam int HS_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    INIT,
    DRAIN,
    IDLE,
    ACK_HI,
    ACK_LO
  } hs_state_t;

endpackage

// File: rtl/hs_sync.sv
// N-flop level synchroniser for a single asynchronous input; all flops clear on reset.
module hs_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[N-2:0], d};
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/hs_ack_responder.sv
// Clocked 4-phase handshake terminator: acknowledges requests from an async
// stage chain, counts completed handshakes and holds off new ones when disabled.
module hs_ack_responder
  import hs_pkg::*;
#(
  parameter int CNT_W       = HS_CNT_W,
  parameter int SYNC_STAGES = HS_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ri,
  input  logic             en,
  input  logic             clear,
  output logic             ao,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             overflow,
  output logic             busy
);

  hs_state_t  state, state_d;
  logic       ri_s;
  logic [2:0] flush_cnt;
  logic       flush_done;
  logic       hs_done;
  logic       ao_d;

  hs_sync #(.N(SYNC_STAGES)) u_ri_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ri),
    .q     (ri_s)
  );

  // Holds INIT long enough for any stale level to clear the synchroniser.
  assign flush_done = (flush_cnt == 3'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (!rst_n)                         flush_cnt <= '0;
    else if (state == INIT && !flush_done) flush_cnt <= flush_cnt + 3'd1;
  end

  always_comb begin
    state_d = state;
    hs_done = 1'b0;
    case (state)
      INIT:    if (flush_done) state_d = ri_s ? DRAIN : IDLE;
      DRAIN:   if (!ri_s) state_d = IDLE;
      IDLE:    if (ri_s && en) state_d = ACK_HI;
      ACK_HI: begin
        if (!ri_s) begin
          state_d = ACK_LO;
          hs_done = 1'b1;
        end
      end
      ACK_LO:  state_d = IDLE;
      default: state_d = INIT;
    endcase
    ao_d = (state_d == ACK_HI);
  end

  // ao and done come straight from flops so the async stage never sees a decode glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      ao    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      ao    <= ao_d;
      done  <= hs_done;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (hs_done) begin
      if (clear) begin
        count    <= CNT_W'(1);
        overflow <= 1'b0;
      end else begin
        count <= count + CNT_W'(1);
        if (&count) overflow <= 1'b1;
      end
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hs_ack_responder.sv
// Directed bench for hs_ack_responder: a default-width instance and a 4-bit counter
// instance share every input so wrap behaviour can be observed alongside the main one.
module tb_hs_ack_responder;

  logic        clk = 1'b0;
  logic        rst_n, ri, en, clear;
  logic        ao_a, done_a, ovf_a, busy_a;
  logic [15:0] cnt_a;
  logic        ao_b, done_b, ovf_b, busy_b;
  logic [3:0]  cnt_b;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int viol        = 0;
  bit mon_en      = 1'b0;
  logic ao_prev   = 1'b0;
  logic ri_edge;

  always #5 clk = ~clk;

  hs_ack_responder dut_a (
    .clk(clk), .rst_n(rst_n), .ri(ri), .en(en), .clear(clear),
    .ao(ao_a), .count(cnt_a), .done(done_a), .overflow(ovf_a), .busy(busy_a)
  );

  hs_ack_responder #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ri(ri), .en(en), .clear(clear),
    .ao(ao_b), .count(cnt_b), .done(done_b), .overflow(ovf_b), .busy(busy_b)
  );

  always @(posedge clk) if (done_a === 1'b1) done_cnt++;

  always @(posedge clk) begin
    ri_edge = ri;
    #1;
    if (mon_en) begin
      if ($isunknown(ao_a))                 viol++;
      if (ao_a && !ao_prev && !ri_edge)     viol++;
      if (!ao_a && ao_prev && ri_edge)      viol++;
      if (ao_a !== ao_b)                    viol++;
    end
    ao_prev = ao_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ao(input logic lvl, input string tag);
    int n = 0;
    while (ao_a !== lvl && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (ao_a !== lvl) begin
      miscompares++;
      $display("FAIL %s timeout: ao=%b required %b", tag, ao_a, lvl);
    end
  endtask

  task automatic do_hs(input int d_req, input int d_ack);
    repeat (d_req) tick();
    ri = 1'b1;
    wait_ao(1'b1, "hs_rise");
    repeat (d_ack) tick();
    ri = 1'b0;
    wait_ao(1'b0, "hs_fall");
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ri = 1'b0; en = 1'b1; clear = 1'b0;
    tick(); tick();
    vectors++;
    if ({ao_a, done_a, ovf_a, busy_a} !== 4'b0001 || cnt_a !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: ao/done/ovf/busy=%b count=%0d required 0001 count=0",
               {ao_a, done_a, ovf_a, busy_a}, cnt_a);
    end
    rst_n = 1'b1;
    tick(); tick();
    vectors++;
    if (busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL init_busy: busy=%b required 1", busy_a);
    end
    tick();
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL init_exit: busy=%b required 0", busy_a);
    end
  endtask

  task automatic test_single();
    ri = 1'b1;
    tick(); tick();
    vectors++;
    if (ao_a !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: ao=%b required 0", ao_a);
    end
    tick();
    vectors++;
    if (ao_a !== 1'b1) begin
      miscompares++;
      $display("FAIL single_rise: ao=%b required 1", ao_a);
    end
    ri = 1'b0;
    tick(); tick();
    vectors++;
    if (ao_a !== 1'b1 || cnt_a !== 16'd0) begin
      miscompares++;
      $display("FAIL single_hold: ao=%b count=%0d required ao=1 count=0", ao_a, cnt_a);
    end
    tick();
    vectors++;
    if (ao_a !== 1'b0 || done_a !== 1'b1 || cnt_a !== 16'd1) begin
      miscompares++;
      $display("FAIL single_fall: ao=%b done=%b count=%0d required 0 1 1", ao_a, done_a, cnt_a);
    end
    tick();
    vectors++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: done=%b busy=%b required 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    en = 1'b0;
    ri = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ao_a !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_hold: ao high in %0d cycles required 0", bad);
    end
    en = 1'b1;
    tick();
    vectors++;
    if (ao_a !== 1'b1 || cnt_a !== 16'd1) begin
      miscompares++;
      $display("FAIL bp_release: ao=%b count=%0d required ao=1 count=1", ao_a, cnt_a);
    end
    ri = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (ao_a !== 1'b0 || cnt_a !== 16'd2) begin
      miscompares++;
      $display("FAIL bp_complete: ao=%b count=%0d required ao=0 count=2", ao_a, cnt_a);
    end
    tick();
  endtask

  task automatic test_wrap();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (cnt_b !== 4'd0 || cnt_a !== 16'd0) begin
      miscompares++;
      $display("FAIL wrap_clear0: count4=%0d count16=%0d required 0 0", cnt_b, cnt_a);
    end
    for (int i = 0; i < 16; i++) do_hs(0, 0);
    vectors++;
    if (cnt_b !== 4'd0 || ovf_b !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_4bit: count=%0d ovf=%b required 0 1", cnt_b, ovf_b);
    end
    vectors++;
    if (cnt_a !== 16'd16 || ovf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_16bit: count=%0d ovf=%b required 16 0", cnt_a, ovf_a);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (ovf_b !== 1'b0 || cnt_b !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap_clear: ovf=%b count=%0d required 0 0", ovf_b, cnt_b);
    end
    do_hs(0, 0);
    vectors++;
    if (cnt_b !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap_after: count=%0d required 1", cnt_b);
    end
  endtask

  task automatic test_clear_collision();
    for (int i = 0; i < 8; i++) do_hs(1, 1);
    vectors++;
    if (cnt_a !== 16'd9) begin
      miscompares++;
      $display("FAIL coll_pre: count=%0d required 9", cnt_a);
    end
    ri = 1'b1;
    wait_ao(1'b1, "coll_rise");
    ri = 1'b0;
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (ao_a !== 1'b0 || cnt_a !== 16'd1 || ovf_a !== 1'b0 || done_a !== 1'b1) begin
      miscompares++;
      $display("FAIL coll_edge: ao=%b count=%0d ovf=%b done=%b required 0 1 0 1",
               ao_a, cnt_a, ovf_a, done_a);
    end
    tick();
  endtask

  task automatic test_reset_ack_hi();
    int d0;
    ri = 1'b1;
    wait_ao(1'b1, "rst_rise");
    d0 = done_cnt;
    rst_n = 1'b0;
    tick();
    vectors++;
    if (ao_a !== 1'b0 || cnt_a !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_edge: ao=%b count=%0d required 0 0", ao_a, cnt_a);
    end
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    vectors++;
    if (ao_a !== 1'b0 || busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_drain: ao=%b busy=%b required 0 1", ao_a, busy_a);
    end
    ri = 1'b0;
    repeat (4) tick();
    vectors++;
    if (busy_a !== 1'b0 || cnt_a !== 16'd0 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL rst_nocount: busy=%b count=%0d done_pulses=%0d required 0 0 0",
               busy_a, cnt_a, done_cnt - d0);
    end
    do_hs(0, 0);
    vectors++;
    if (cnt_a !== 16'd1) begin
      miscompares++;
      $display("FAIL rst_after: count=%0d required 1", cnt_a);
    end
  endtask

  task automatic test_ring();
    int d0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    d0 = done_cnt;
    viol = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 1000; i++) do_hs(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    tick();
    mon_en = 1'b0;
    vectors++;
    if (cnt_a !== 16'd1000) begin
      miscompares++;
      $display("FAIL ring_count: count=%0d required 1000", cnt_a);
    end
    vectors++;
    if (cnt_b !== 4'd8 || ovf_b !== 1'b1) begin
      miscompares++;
      $display("FAIL ring_count4: count=%0d ovf=%b required 8 1", cnt_b, ovf_b);
    end
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL ring_protocol: violations=%0d required 0", viol);
    end
    vectors++;
    if (done_cnt - d0 != 1000) begin
      miscompares++;
      $display("FAIL ring_done: pulses=%0d required 1000", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_clear_collision();
    test_reset_ack_hi();
    test_ring();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hs_ack_responder.md
# hs_ack_responder

Synchronous 4-phase (return-to-zero) handshake responder that terminates the request output of a self-timed stage chain and returns its acknowledge. The request input is asynchronous to `clk` and is synchronised before use. The block acknowledges each request, counts completed handshakes, and applies back-pressure when disabled. It sits at the output end of the asynchronous counter/pipeline rings and measures their throughput in the clocked domain.

## Interface
- `CNT_W`, default 16: completed-handshake counter width.
- `SYNC_STAGES`, default 2 (legal 2..4): flops in the request synchroniser.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ri`  in  1  request from the last async stage (`ro` of that stage). Asynchronous.
- `en`  in  1  permits acknowledging a new request.
- `clear`  in  1  synchronous clear of `count` and `overflow`.
- `ao`  out  1  acknowledge to the async stage. Registered, glitch-free.
- `count`  out  CNT_W  completed handshakes, modulo 2^CNT_W.
- `done`  out  1  one-cycle pulse per completed handshake.
- `overflow`  out  1  sticky; set when `count` wraps.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `ri` passes through a SYNC_STAGES flop chain to produce `ri_s`. All flops reset to 0.
- The FSM has five states:
  - **INIT**: entered on reset. Waits SYNC_STAGES+1 cycles so the synchroniser flushes. Then goes to DRAIN if `ri_s`=1, else IDLE.
  - **DRAIN**: `ao`=0. Waits for `ri_s`=0, then goes to IDLE. No count. This discards a request that was pending across reset.
  - **IDLE**: `ao`=0. If `ri_s`=1 and `en`=1, goes to ACK_HI. If `en`=0, the request is held off indefinitely.
  - **ACK_HI**: `ao`=1. When `ri_s`=0, goes to ACK_LO. `en` is ignored in this state.
  - **ACK_LO**: `ao`=0. Goes to IDLE on the next edge. On the entry edge, `count` increments and `done` pulses.
- `ao` is driven only from a state flop. There is no combinational path from `ri` to `ao`.
- Counter: `count` goes from 2^CNT_W−1 to 0 on increment. `overflow` sets on that same edge.
- Clear with an increment on the same edge: the result is `count`=1 and `overflow`=0.
- Clear alone: the result is `count`=0 and `overflow`=0.
- Protocol: `ri` must not fall while `ao`=0 after rising, and must not rise while `ao`=1. The responder needs no error handling for this, because the FSM only watches the level it expects.

## Timing
- Reset values: `ao`=0, `count`=0, `done`=0, `overflow`=0, `busy`=1 (INIT).
- After `rst_n` returns high, INIT lasts SYNC_STAGES+1 cycles.
- Edge numbering: `ri` is first sampled high at edge t. `ri_s` is high after edge t+SYNC_STAGES−1. `ao` rises at edge t+SYNC_STAGES.
- The same SYNC_STAGES-edge latency applies from `ri` sampled low to `ao` falling.
- `done` and the `count` update happen on the edge where `ao` falls.
- Minimum full handshake: 2·SYNC_STAGES+1 cycles. With the defaults, maximum throughput is 1 handshake per 5 cycles.
- Reset mid-handshake (`rst_n` sampled low): `ao` goes to 0 at that edge. The interrupted handshake is not counted. If `ri` is still high when INIT ends, it is drained and not counted.

## Structure
- Package `hs_pkg` holds:
  - the state enum `hs_state_t` (INIT, DRAIN, IDLE, ACK_HI, ACK_LO);
  - the default constants `HS_CNT_W`=16 and `HS_SYNC_STAGES`=2.
- Sub-module `hs_sync`: a parameterised N-flop synchroniser with synchronous active-low reset. It is instantiated once, for `ri`.
- The top contains the FSM, the INIT flush counter and the handshake counter.

## Test plan
- **Reset then single handshake** (defaults): raise `ri`, wait for `ao`=1, drop `ri`. Expect `ao` high 2 edges after `ri` is sampled high, one `done` pulse, `count`=1, `busy`=0 afterwards.
- **Back-pressure**: `en`=0, `ri`=1 for 20 cycles. Expect `ao`=0 throughout. Set `en`=1: `ao`=1 one edge later, and `count` unchanged until `ri` falls.
- **Wrap**: `CNT_W`=4, 16 handshakes. Expect `count`=0 and `overflow`=1. Then `clear`: `overflow`=0. Then one handshake: `count`=1.
- **Clear collision**: assert `clear` on the edge `ao` falls with `count`=9. Expect `count`=1, `overflow`=0, `done`=1.
- **Reset during ACK_HI**: `ri` held high through reset. Expect `ao`=0 at the reset edge and no `done`. Drop `ri`, then run one full handshake: `count`=1.
- **Async ring closure**: connect to a behavioural 4-phase initiator with random 0–7 cycle response delay for 1000 handshakes. Expect `count`=1000, `ri` and `ao` never high/low out of protocol order, and no X on `ao`.
